// File: rtl/mem_writeback.sv
// Memory/writeback stage: performs data-memory loads and stores over a req/ack port,
// drives the register-file write port, counts retired instructions and flags memory timeouts.
module mem_writeback #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [3:0]        modified_opcode,
  input  logic [31:0]       alu_result,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [15:0]       retired,
  output logic              mem_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WB} state_t;
  typedef enum logic [1:0] {CL_W, CL_N, CL_L, CL_S} op_class_t;

  // Last counter value before the access is abandoned; the counter is 8 bits wide.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic op_class_t decode_class(input logic [3:0] op);
    op_class_t cls;
    case (op)
      4'hB, 4'hF: cls = CL_N;
      4'hD:       cls = CL_L;
      4'hE:       cls = CL_S;
      default:    cls = CL_W;
    endcase
    return cls;
  endfunction

  state_t            state_r,     state_s;
  logic              mem_req_r,   mem_req_s;
  logic              mem_we_r,    mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic              rf_we_r,     rf_we_s;
  logic [3:0]        rf_waddr_r,  rf_waddr_s;
  logic [31:0]       rf_wdata_r,  rf_wdata_s;
  logic [15:0]       retired_r,   retired_s;
  logic              mem_err_r,   mem_err_s;
  logic [7:0]        tmo_cnt_r,   tmo_cnt_s;

  logic              in_ready_s;
  logic              accept_s;
  logic [3:0]        rd_s;
  op_class_t         class_s;
  logic              unused_instr_s;

  assign in_ready_s     = (state_r != ST_MEM);
  assign accept_s       = in_valid & in_ready_s;
  assign rd_s           = instruction[22:19];
  assign class_s        = decode_class(modified_opcode);
  assign unused_instr_s = ^{instruction[31:23], instruction[18:0]};

  // Next-state and next-output decode for the IDLE/MEM/WB controller.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    rf_we_s     = 1'b0;
    rf_waddr_s  = rf_waddr_r;
    rf_wdata_s  = rf_wdata_r;
    retired_s   = retired_r;
    mem_err_s   = mem_err_r;
    tmo_cnt_s   = tmo_cnt_r;

    case (state_r)
      // WB decodes a new accept exactly like IDLE so class W runs at one per cycle.
      ST_IDLE, ST_WB: begin
        state_s = ST_IDLE;
        if (accept_s) begin
          case (class_s)
            CL_W: begin
              state_s    = ST_WB;
              rf_we_s    = 1'b1;
              rf_waddr_s = rd_s;
              rf_wdata_s = alu_result;
              retired_s  = retired_r + 16'd1;
            end
            CL_N: begin
              retired_s = retired_r + 16'd1;
            end
            CL_L: begin
              state_s    = ST_MEM;
              mem_req_s  = 1'b1;
              mem_we_s   = 1'b0;
              mem_addr_s = mem_addr_in;
              rf_waddr_s = rd_s;
              tmo_cnt_s  = 8'd0;
            end
            CL_S: begin
              state_s     = ST_MEM;
              mem_req_s   = 1'b1;
              mem_we_s    = 1'b1;
              mem_addr_s  = mem_addr_in;
              mem_wdata_s = store_data;
              tmo_cnt_s   = 8'd0;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      // An ack on the final counted cycle takes priority over the timeout.
      ST_MEM: begin
        if (mem_ack) begin
          mem_req_s = 1'b0;
          tmo_cnt_s = 8'd0;
          retired_s = retired_r + 16'd1;
          if (mem_we_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_WB;
            rf_we_s    = 1'b1;
            rf_wdata_s = mem_rdata;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s   = ST_IDLE;
          mem_req_s = 1'b0;
          mem_err_s = 1'b1;
          tmo_cnt_s = 8'd0;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= 4'd0;
      rf_wdata_r  <= 32'd0;
      retired_r   <= 16'd0;
      mem_err_r   <= 1'b0;
      tmo_cnt_r   <= 8'd0;
    end else begin
      state_r     <= state_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      rf_we_r     <= rf_we_s;
      rf_waddr_r  <= rf_waddr_s;
      rf_wdata_r  <= rf_wdata_s;
      retired_r   <= retired_s;
      mem_err_r   <= mem_err_s;
      tmo_cnt_r   <= tmo_cnt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign retired   = retired_r;
  assign mem_err   = mem_err_r;

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Stage directly downstream of the ALU. Accepts one ALU-completed instruction per handshake: the instruction word, the ALU's condition-resolved opcode, and the ALU result.
- Performs data-memory load (opcode D) or store (opcode E) through a req/ack port, then drives the register-file write port.
- Owns the retire counter and the sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req stays high without mem_ack before the access is abandoned (legal range 1..255).
- ADDR_W, 16, data-memory address width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has an instruction for this stage
- in_ready  output  1  stage can accept this cycle
- instruction  input  32  instruction word; rd = instruction[22:19]
- modified_opcode  input  4  opcode after condition evaluation; F = NOP
- alu_result  input  32  ALU result
- mem_addr_in  input  ADDR_W  load/store address (from source register 2)
- store_data  input  32  store data (from source register 1)
- mem_req  output  1  memory request
- mem_we  output  1  1 = store, 0 = load; valid while mem_req=1
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  32  store data
- mem_ack  input  1  memory completion, single-cycle pulse
- mem_rdata  input  32  load data, valid with mem_ack
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_waddr  output  4  destination register
- rf_wdata  output  32  write data
- retired  output  16  instructions retired, wraps
- mem_err  output  1  sticky timeout error

Behaviour:
- Reset (reset=0, async): state IDLE. mem_req, mem_we, rf_we, mem_err = 0. mem_addr, mem_wdata, rf_waddr, rf_wdata, retired = 0. Timeout counter = 0. Reset asserted mid-access drops mem_req immediately; no writeback occurs.
- States: IDLE, MEM, WB.
- in_ready = 1 in IDLE and WB; 0 in MEM. Accept = in_valid & in_ready.
- Instruction classes at accept:
  - Class W: opcodes 0-A and C. Latch rd and alu_result. Next state WB.
  - Class N: opcodes B and F. No writeback, no memory access. retired increments on the accept cycle. Next state IDLE.
  - Class L: opcode D. Latch rd. mem_addr = mem_addr_in, mem_we = 0, mem_req = 1. Next state MEM.
  - Class S: opcode E. mem_addr = mem_addr_in, mem_wdata = store_data, mem_we = 1, mem_req = 1. Next state MEM.
- WB (one cycle):
  - rf_we = 1 with the latched rf_waddr/rf_wdata. retired increments in this cycle.
  - An accept in the same cycle is decoded as from IDLE, so back-to-back class W sustains 1 instruction/cycle.
- MEM:
  - mem_req and the address/data/we outputs are held stable until ack or timeout.
  - Timeout counter increments each MEM cycle without ack.
  - mem_ack with load: capture mem_rdata into rf_wdata, drop mem_req next edge, go WB. rf_we rises exactly 1 cycle after the ack cycle.
  - mem_ack with store: drop mem_req, retired += 1, go IDLE. No rf_we.
  - Counter reaches MEM_TIMEOUT without ack: drop mem_req, set mem_err = 1, go IDLE. Nothing retires, no rf_we.
  - mem_ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins, no error.
- mem_ack while not in MEM is ignored.
- mem_err clears only on reset.
- Latency from accept:
  - Class W: rf_we on the next cycle.
  - Class L: mem_req on the next cycle; rf_we 1 cycle after mem_ack.
- rf_we is 0 in every state except WB.
- rd is not special-cased; a write to register 0 is performed.
- retired wraps FFFF -> 0000 without flag.

Test Plan:
- Reset, then accept opcode 0, rd=3, alu_result=0x0000_0007 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=7, retired=1.
- Four consecutive class W accepts with in_valid held high -> in_ready stays 1, rf_we high 4 consecutive cycles, retired=4.
- Load (D), rd=5, mem_addr_in=0x0040, memory acks after 3 cycles with rdata 0xDEADBEEF -> mem_req high 3 cycles, mem_we=0, addr 0x0040, in_ready=0 throughout, rf_we one cycle after ack with rf_waddr=5, rf_wdata=0xDEADBEEF.
- Store (E), store_data=0x12345678, addr 0x0010, immediate ack -> mem_we=1, mem_wdata=0x12345678, no rf_we, retired+1, in_ready returns 1.
- Load with no ack, MEM_TIMEOUT=16 -> mem_req drops after 16 cycles, mem_err=1 and stays set, no rf_we, retired unchanged. Repeat with ack arriving on cycle 16 -> normal completion, mem_err=0.
- Opcode F and opcode B accepted -> no rf_we, no mem_req, retired +1 each. Assert reset mid-load -> mem_req=0 immediately, all outputs 0.
